// File: rtl/board_vga_renderer.sv
// Life-board VGA renderer: latches the 256-cell board once per frame and draws a
// 16x16 grid with grid lines and a blinking edit cursor, through a 2-stage pipeline.
module board_vga_renderer #(
    parameter int H_START    = 144,
    parameter int V_START    = 35,
    parameter int GRID_X     = 192,
    parameter int GRID_Y     = 112,
    parameter int BLINK_LOG2 = 5
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         bright,
    input  logic [9:0]   hCount,
    input  logic [9:0]   vCount,
    input  logic         hSync_i,
    input  logic         vSync_i,
    input  logic [255:0] board,
    input  logic [3:0]   cursor_row,
    input  logic [3:0]   cursor_col,
    input  logic         cursor_en,
    output logic [11:0]  rgb,
    output logic         hSync_o,
    output logic         vSync_o,
    output logic         snap_pulse
);

    localparam int CNT_W = BLINK_LOG2 + 1;
    localparam logic signed [10:0] X_OFF = 11'(H_START + GRID_X);
    localparam logic signed [10:0] Y_OFF = 11'(V_START + GRID_Y);

    logic [255:0]     snapshot;
    logic [CNT_W-1:0] frame_cnt;
    logic             origin_q;
    logic             at_origin;
    logic             fs;
    logic             blink_on;

    logic signed [10:0] px;
    logic signed [10:0] py;
    logic               in_grid;

    logic       s1_bright;
    logic       s1_in_grid;
    logic [3:0] s1_row;
    logic [3:0] s1_col;
    logic [3:0] s1_sx;
    logic [3:0] s1_sy;
    logic       s1_alive;
    logic       h_d1;
    logic       v_d1;
    logic [11:0] rgb_next;

    // The controller may hold 0,0 for several clocks; only the first one starts a frame.
    assign at_origin = (hCount == 10'd0) && (vCount == 10'd0);
    assign fs        = at_origin && !origin_q;
    assign blink_on  = ~frame_cnt[BLINK_LOG2];

    // Zero-extend before subtracting so positions left of/above the grid go negative
    // instead of wrapping back into it.
    assign px      = $signed({1'b0, hCount}) - X_OFF;
    assign py      = $signed({1'b0, vCount}) - Y_OFF;
    assign in_grid = (px[10:8] == 3'b000) && (py[10:8] == 3'b000);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: the snapshot is reset as well; the grid must show an empty board
            // before the first frame start rather than power-up garbage.
            snapshot   <= '0;
            frame_cnt  <= '0;
            origin_q   <= 1'b0;
            snap_pulse <= 1'b0;
        end else begin
            origin_q   <= at_origin;
            snap_pulse <= fs;
            if (fs) begin
                snapshot  <= board;
                frame_cnt <= frame_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_bright  <= 1'b0;
            s1_in_grid <= 1'b0;
            s1_row     <= '0;
            s1_col     <= '0;
            s1_sx      <= '0;
            s1_sy      <= '0;
            s1_alive   <= 1'b0;
            h_d1       <= 1'b1;
            v_d1       <= 1'b1;
            rgb        <= 12'h000;
            hSync_o    <= 1'b1;
            vSync_o    <= 1'b1;
        end else begin
            s1_bright  <= bright;
            s1_in_grid <= in_grid;
            s1_row     <= py[7:4];
            s1_col     <= px[7:4];
            s1_sx      <= px[3:0];
            s1_sy      <= py[3:0];
            s1_alive   <= snapshot[{py[7:4], px[7:4]}];
            h_d1       <= hSync_i;
            v_d1       <= vSync_i;
            rgb        <= rgb_next;
            hSync_o    <= h_d1;
            vSync_o    <= v_d1;
        end
    end

    // Cursor inputs are used here undelayed so a cursor move shows up immediately.
    always_comb begin
        rgb_next = 12'h000;
        if (!s1_bright)
            rgb_next = 12'h000;
        else if (!s1_in_grid)
            rgb_next = 12'h111;
        else if (cursor_en && blink_on && s1_row == cursor_row && s1_col == cursor_col &&
                 (s1_sx == 4'h0 || s1_sx == 4'hF || s1_sy == 4'h0 || s1_sy == 4'hF))
            rgb_next = 12'hF00;
        else if (s1_sx == 4'h0 || s1_sy == 4'h0)
            rgb_next = 12'h444;
        else if (s1_alive)
            rgb_next = 12'h0F0;
        else
            rgb_next = 12'h000;
    end

endmodule

// File: tb/tb_board_vga_renderer.sv
// Directed self-checking bench for board_vga_renderer: reset, cell colours, frame
// snapshot timing, cursor blink, grid boundaries and sync delay.
module tb_board_vga_renderer;

    logic         clk = 1'b0;
    logic         reset;
    logic         bright;
    logic [9:0]   hCount;
    logic [9:0]   vCount;
    logic         hSync_i;
    logic         vSync_i;
    logic [255:0] board;
    logic [3:0]   cursor_row;
    logic [3:0]   cursor_col;
    logic         cursor_en;
    logic [11:0]  rgb;
    logic         hSync_o;
    logic         vSync_o;
    logic         snap_pulse;

    int errors = 0;
    int checks = 0;

    board_vga_renderer dut (
        .clk(clk), .reset(reset), .bright(bright), .hCount(hCount), .vCount(vCount),
        .hSync_i(hSync_i), .vSync_i(vSync_i), .board(board),
        .cursor_row(cursor_row), .cursor_col(cursor_col), .cursor_en(cursor_en),
        .rgb(rgb), .hSync_o(hSync_o), .vSync_o(vSync_o), .snap_pulse(snap_pulse)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [11:0] got, input logic [11:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic frame_start();
        hCount = 10'd0;
        vCount = 10'd0;
        step();
        hCount = 10'd1;
        step();
    endtask

    task automatic pixel(input int h, input int v, input logic [11:0] exp, input string tag);
        hCount = 10'(h);
        vCount = 10'(v);
        step();
        step();
        chk(tag, rgb, exp);
    endtask

    initial begin
        int pulses;
        logic [15:0] hpat;
        logic [15:0] vpat;

        reset      = 1'b1;
        bright     = 1'b1;
        hCount     = 10'd200;
        vCount     = 10'd100;
        hSync_i    = 1'b1;
        vSync_i    = 1'b1;
        board      = '0;
        cursor_row = 4'd0;
        cursor_col = 4'd0;
        cursor_en  = 1'b0;
        step();
        step();
        reset = 1'b0;
        step();
        step();
        step();

        // Mid-line reset with origin and low syncs present.
        reset   = 1'b1;
        hCount  = 10'd0;
        vCount  = 10'd0;
        hSync_i = 1'b0;
        vSync_i = 1'b0;
        step();
        step();
        step();
        chk("reset_rgb", rgb, 12'h000);
        chk("reset_hsync", {11'd0, hSync_o}, 12'd1);
        chk("reset_vsync", {11'd0, vSync_o}, 12'd1);
        chk("reset_snap", {11'd0, snap_pulse}, 12'd0);
        reset   = 1'b0;
        hCount  = 10'd200;
        vCount  = 10'd100;
        hSync_i = 1'b1;
        vSync_i = 1'b1;
        step();
        chk("refill_1cyc", rgb, 12'h000);
        step();
        chk("refill_2cyc", rgb, 12'h111);

        // Single live cell at row 0, col 0.
        board    = '0;
        board[0] = 1'b1;
        frame_start();
        pixel(341, 152, 12'h0F0, "cell0_alive");
        pixel(357, 152, 12'h000, "cell1_dead");
        pixel(352, 152, 12'h444, "vline_px16");
        pixel(341, 163, 12'h444, "hline_py16");

        // Held origin gives exactly one snapshot pulse.
        pulses = 0;
        hCount = 10'd0;
        vCount = 10'd0;
        for (int i = 0; i < 4; i++) begin
            step();
            if (snap_pulse === 1'b1) pulses++;
        end
        hCount = 10'd1;
        step();
        if (snap_pulse === 1'b1) pulses++;
        chk("held_origin_pulses", 12'(pulses), 12'd1);

        // Mid-frame board change must not show until the next frame start.
        board = '1;
        pixel(357, 152, 12'h000, "midframe_old_dead");
        pixel(341, 152, 12'h0F0, "midframe_old_alive");
        frame_start();
        pixel(357, 152, 12'h0F0, "newframe_alive");

        // Cursor blink: reset clears frame counter and snapshot.
        reset = 1'b1;
        step();
        reset      = 1'b0;
        cursor_en  = 1'b1;
        cursor_row = 4'd3;
        cursor_col = 4'd7;
        pixel(448, 203, 12'hF00, "cursor_on");
        for (int i = 0; i < 32; i++) frame_start();
        pixel(448, 203, 12'h444, "cursor_blink_off");
        pixel(456, 203, 12'h0F0, "cursor_interior_off");
        for (int i = 0; i < 32; i++) frame_start();
        pixel(448, 203, 12'hF00, "cursor_blink_on");
        pixel(456, 203, 12'h0F0, "cursor_interior_on");
        cursor_col = 4'd8;
        pixel(448, 203, 12'h444, "cursor_other_col");
        cursor_col = 4'd7;
        cursor_en  = 1'b0;
        pixel(448, 203, 12'h444, "cursor_disabled");

        // Grid boundaries and blanking.
        pixel(335, 152, 12'h111, "px_minus1");
        pixel(592, 152, 12'h111, "px_256");
        pixel(341, 146, 12'h111, "py_minus1");
        pixel(341, 403, 12'h111, "py_256");
        pixel(591, 402, 12'h0F0, "last_cell");
        bright = 1'b0;
        pixel(341, 152, 12'h000, "blank_in_grid");
        pixel(200, 100, 12'h000, "blank_outside");
        bright = 1'b1;

        // Sync passthrough delayed exactly two cycles.
        hpat = 16'b1011_0010_1110_0101;
        vpat = 16'b0110_1101_0001_1011;
        for (int k = 0; k < 16; k++) begin
            hSync_i = hpat[k];
            vSync_i = vpat[k];
            step();
            if (k >= 1) begin
                chk($sformatf("hsync_delay_%0d", k), {11'd0, hSync_o}, {11'd0, hpat[k-1]});
                chk($sformatf("vsync_delay_%0d", k), {11'd0, vSync_o}, {11'd0, vpat[k-1]});
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
